// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
//  Package     : lc3b_types
//  Description : Shared types for the lc3b MEM stage: memory-op class,
//                access-controller state encoding and byte-enable constants.
//  Revision    : 1.0  initial release
// ============================================================================
package lc3b_types;

    // Load/store class of the instruction sitting in MEM
    typedef enum logic [2:0] {
        MOP_NONE = 3'd0,
        MOP_LDW  = 3'd1,
        MOP_LDB  = 3'd2,
        MOP_STW  = 3'd3,
        MOP_STB  = 3'd4,
        MOP_LDI  = 3'd5,
        MOP_STI  = 3'd6
    } mem_op_t;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    localparam logic [1:0] BE_WORD = 2'b11;

    // True for op codes that start a memory sequence (unused code 7 is ignored)
    function automatic logic op_is_access(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd6);
    endfunction

    // True for ops whose final access returns data to the register file
    function automatic logic op_is_read(input mem_op_t op);
        return (op == MOP_LDW) || (op == MOP_LDB) || (op == MOP_LDI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3b_byte_lane.sv
`default_nettype none
// ============================================================================
//  Module      : lc3b_byte_lane
//  Description : Combinational byte-lane steering. Selects and zero-extends
//                the addressed byte for LDB, replicates the low source byte
//                for STB and produces the matching write byte enables.
//  Revision    : 1.0  initial release
// ============================================================================
module lc3b_byte_lane
    import lc3b_types::*;
(
    input  logic        i_byte_op,
    input  logic        i_sel_hi,
    input  logic [15:0] i_rdata,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_ld_value,
    output logic [15:0] o_wdata,
    output logic [1:0]  o_byte_en
);

    logic [7:0] w_sel_byte;

    assign w_sel_byte = i_sel_hi ? i_rdata[15:8] : i_rdata[7:0];

    // Byte ops steer a single lane; word ops pass straight through
    always_comb begin
        o_ld_value = i_rdata;
        o_wdata    = i_wdata;
        o_byte_en  = BE_WORD;
        if (i_byte_op) begin
            o_ld_value = {8'h00, w_sel_byte};
            o_wdata    = {i_wdata[7:0], i_wdata[7:0]};
            o_byte_en  = i_sel_hi ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : lc3b MEM-stage access controller. Turns the MEM load/store
//                class into a read/write handshake, sequences the two-access
//                LDI/STI indirection, stalls the pipe until completion and
//                returns load data plus forwarding status.
//                Optional feature macro: MEM_PERF_EN (saturating access and
//                stall-cycle counters on perf_acc_cnt / perf_stall_cnt).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_ctrl
    import lc3b_types::*;
`ifdef MEM_PERF_EN
#(
    parameter int PERF_CNT_W = 16
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [15:0] addr,
    input  logic [15:0] st_data,
    input  logic        flush,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp,
    output logic        stall,
    output logic [15:0] ld_data,
    output logic        ld_valid,
    output logic        r_mem,
    output logic        indirect_op,
    output logic        mem_resp_fwd
`ifdef MEM_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_acc_cnt,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt
`endif
);

    mem_state_t  r_state;
    mem_op_t     r_op;
    logic [15:0] r_addr;
    logic [15:0] r_st_data;
    logic [14:0] r_ptr;       // pointer word address; bit 0 is never used
    logic [15:0] r_ld_data;
    logic        r_ld_valid;
    logic        r_squash;

    logic        w_start;
    logic        w_acc1;
    logic        w_acc2;
    logic        w_ind;
    logic        w_rd_op;
    logic        w_byte;
    logic        w_read;
    logic        w_write;
    logic [15:0] w_word_addr;
    logic [15:0] w_lane_ld;
    logic [15:0] w_lane_wdata;
    logic [1:0]  w_lane_be;

    assign w_start = (r_state == IDLE) && op_valid && op_is_access(op) && !flush;
    assign w_acc1  = (r_state == ACC1);
    assign w_acc2  = (r_state == ACC2);
    assign w_ind   = (r_op == MOP_LDI) || (r_op == MOP_STI);
    assign w_rd_op = op_is_read(r_op);
    assign w_byte  = (r_op == MOP_LDB) || (r_op == MOP_STB);

    // The pointer fetch of LDI/STI is a read; the second access follows the op
    always_comb begin
        w_read  = 1'b0;
        w_write = 1'b0;
        if (w_acc1) begin
            w_write = (r_op == MOP_STW) || (r_op == MOP_STB);
            w_read  = !w_write;
        end else if (w_acc2) begin
            w_read  = (r_op == MOP_LDI);
            w_write = (r_op == MOP_STI);
        end
    end

    assign w_word_addr = w_acc2 ? {r_ptr, 1'b0} : {r_addr[15:1], 1'b0};

    lc3b_byte_lane u_byte_lane (
        .i_byte_op  (w_byte),
        .i_sel_hi   (r_addr[0]),
        .i_rdata    (mem_rdata),
        .i_wdata    (r_st_data),
        .o_ld_value (w_lane_ld),
        .o_wdata    (w_lane_wdata),
        .o_byte_en  (w_lane_be)
    );

    assign mem_read        = w_read;
    assign mem_write       = w_write;
    assign mem_address     = (w_read || w_write) ? w_word_addr : 16'h0000;
    assign mem_wdata       = w_write ? w_lane_wdata : 16'h0000;
    assign mem_byte_enable = w_write ? w_lane_be : 2'b00;

    assign stall        = w_start || w_acc1 || w_acc2;
    assign r_mem        = (r_state != IDLE) && w_rd_op;
    assign indirect_op  = w_acc1 && w_ind;
    assign mem_resp_fwd = mem_resp && r_mem && !indirect_op;
    assign ld_data      = r_ld_data;
    assign ld_valid     = r_ld_valid;

    // Access sequencer: a flush never aborts an access, it only squashes writeback
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_op       <= MOP_NONE;
            r_addr     <= 16'h0000;
            r_st_data  <= 16'h0000;
            r_ptr      <= 15'h0000;
            r_ld_data  <= 16'h0000;
            r_ld_valid <= 1'b0;
            r_squash   <= 1'b0;
        end else begin
            r_ld_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_squash <= 1'b0;
                    if (w_start) begin
                        r_op      <= mem_op_t'(op);
                        r_addr    <= addr;
                        r_st_data <= st_data;
                        r_state   <= ACC1;
                    end
                end
                ACC1: begin
                    if (flush) begin
                        r_squash <= 1'b1;
                    end
                    if (mem_resp) begin
                        if (w_ind) begin
                            r_ptr   <= mem_rdata[15:1];
                            r_state <= ACC2;
                        end else begin
                            if (w_rd_op) begin
                                r_ld_data <= w_lane_ld;
                            end
                            r_ld_valid <= w_rd_op && !(r_squash || flush);
                            r_state    <= DONE;
                        end
                    end
                end
                ACC2: begin
                    if (flush) begin
                        r_squash <= 1'b1;
                    end
                    if (mem_resp) begin
                        if (w_rd_op) begin
                            r_ld_data <= mem_rdata;
                        end
                        r_ld_valid <= w_rd_op && !(r_squash || flush);
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_PERF_EN
    logic [PERF_CNT_W-1:0] r_perf_acc;
    logic [PERF_CNT_W-1:0] r_perf_stall;

    // Saturating counters of completed accesses and stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_acc   <= '0;
            r_perf_stall <= '0;
        end else begin
            if ((w_acc1 || w_acc2) && mem_resp && !(&r_perf_acc)) begin
                r_perf_acc <= r_perf_acc + 1'b1;
            end
            if (stall && !(&r_perf_stall)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign perf_acc_cnt   = r_perf_acc;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Directed self-checking bench for mem_access_ctrl. Inputs are
//                driven 1 time unit after the rising edge and outputs sampled
//                1 time unit later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;
    import lc3b_types::*;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [15:0] addr;
    logic [15:0] st_data;
    logic        flush;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        stall;
    logic [15:0] ld_data;
    logic        ld_valid;
    logic        r_mem;
    logic        indirect_op;
    logic        mem_resp_fwd;
`ifdef MEM_PERF_EN
    logic [15:0] perf_acc_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int stall_cycles;

    mem_access_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .op_valid        (op_valid),
        .op              (op),
        .addr            (addr),
        .st_data         (st_data),
        .flush           (flush),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .stall           (stall),
        .ld_data         (ld_data),
        .ld_valid        (ld_valid),
        .r_mem           (r_mem),
        .indirect_op     (indirect_op),
        .mem_resp_fwd    (mem_resp_fwd)
`ifdef MEM_PERF_EN
        ,
        .perf_acc_cnt    (perf_acc_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b0; op = MOP_NONE; addr = 16'h0; st_data = 16'h0;
        flush = 1'b0; mem_rdata = 16'h0; mem_resp = 1'b0;
        step(); step();
        reset = 1'b0;
        step(); #1;
        total++; if ({mem_read, mem_write, stall, ld_valid, r_mem, indirect_op, mem_resp_fwd} !== 7'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000000", {mem_read, mem_write, stall, ld_valid, r_mem, indirect_op, mem_resp_fwd}); end
        total++; if (ld_data !== 16'h0000) begin bad++; $display("FAIL reset_ld_data got=%h exp=0000", ld_data); end
        total++; if (mem_address !== 16'h0000 || mem_byte_enable !== 2'b00) begin bad++; $display("FAIL reset_addr got=%h/%b exp=0000/00", mem_address, mem_byte_enable); end
`ifdef MEM_PERF_EN
        total++; if (perf_acc_cnt !== 16'd0 || perf_stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_acc_cnt, perf_stall_cnt); end
`endif
    endtask

    // LDW with two wait cycles before the response
    task automatic test_ldw();
        stall_cycles = 0;
        op_valid = 1'b1; op = MOP_LDW; addr = 16'h3001; #1;
        total++; if (stall !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("FAIL ldw_idle_start got stall=%b rd=%b exp 1/0", stall, mem_read); end
        stall_cycles += int'(stall);
        step(); #1;
        total++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 16'h3000) begin bad++; $display("FAIL ldw_acc1 got rd=%b wr=%b a=%h exp 1/0/3000", mem_read, mem_write, mem_address); end
        total++; if (r_mem !== 1'b1 || indirect_op !== 1'b0 || mem_resp_fwd !== 1'b0) begin bad++; $display("FAIL ldw_status got %b%b%b exp 100", r_mem, indirect_op, mem_resp_fwd); end
        stall_cycles += int'(stall);
        step(); #1;
        stall_cycles += int'(stall);
        step();
        mem_resp = 1'b1; mem_rdata = 16'hBEEF; #1;
        total++; if (mem_resp_fwd !== 1'b1 || mem_address !== 16'h3000) begin bad++; $display("FAIL ldw_resp got fwd=%b a=%h exp 1/3000", mem_resp_fwd, mem_address); end
        stall_cycles += int'(stall);
        step();
        mem_resp = 1'b0; op_valid = 1'b0; #1;
        total++; if (stall !== 1'b0 || ld_valid !== 1'b1 || ld_data !== 16'hBEEF) begin bad++; $display("FAIL ldw_done got st=%b v=%b d=%h exp 0/1/beef", stall, ld_valid, ld_data); end
        stall_cycles += int'(stall);
        step(); #1;
        total++; if (ld_valid !== 1'b0 || mem_read !== 1'b0) begin bad++; $display("FAIL ldw_valid_pulse got v=%b rd=%b exp 0/0", ld_valid, mem_read); end
        total++; if (stall_cycles !== 4) begin bad++; $display("FAIL ldw_stall_count got=%0d exp=4", stall_cycles); end
`ifdef MEM_PERF_EN
        total++; if (perf_acc_cnt !== 16'd1 || perf_stall_cnt !== 16'd4) begin bad++; $display("FAIL ldw_perf got=%0d/%0d exp=1/4", perf_acc_cnt, perf_stall_cnt); end
`endif
    endtask

    task automatic test_byte();
        op_valid = 1'b1; op = MOP_LDB; addr = 16'h2005;
        step();
        mem_resp = 1'b1; mem_rdata = 16'hA55A; #1;
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h2004) begin bad++; $display("FAIL ldb_acc1 got rd=%b a=%h exp 1/2004", mem_read, mem_address); end
        step();
        mem_resp = 1'b0; op_valid = 1'b0; #1;
        total++; if (ld_data !== 16'h00A5 || ld_valid !== 1'b1) begin bad++; $display("FAIL ldb_data got d=%h v=%b exp 00a5/1", ld_data, ld_valid); end
        step();
        op_valid = 1'b1; op = MOP_STB; addr = 16'h2004; st_data = 16'h1234;
        step();
        mem_resp = 1'b1; #1;
        total++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 16'h3434 || mem_byte_enable !== 2'b01) begin bad++; $display("FAIL stb_acc1 got wr=%b rd=%b wd=%h be=%b exp 1/0/3434/01", mem_write, mem_read, mem_wdata, mem_byte_enable); end
        total++; if (r_mem !== 1'b0 || mem_resp_fwd !== 1'b0 || mem_address !== 16'h2004) begin bad++; $display("FAIL stb_status got rm=%b fwd=%b a=%h exp 0/0/2004", r_mem, mem_resp_fwd, mem_address); end
        step();
        mem_resp = 1'b0; op_valid = 1'b0; #1;
        total++; if (ld_valid !== 1'b0 || ld_data !== 16'h00A5 || stall !== 1'b0) begin bad++; $display("FAIL stb_done got v=%b d=%h st=%b exp 0/00a5/0", ld_valid, ld_data, stall); end
        step();
    endtask

    task automatic test_ldi();
        op_valid = 1'b1; op = MOP_LDI; addr = 16'h4000;
        step();
        mem_resp = 1'b1; mem_rdata = 16'h5000; #1;
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h4000 || indirect_op !== 1'b1 || mem_resp_fwd !== 1'b0) begin bad++; $display("FAIL ldi_acc1 got rd=%b a=%h ind=%b fwd=%b exp 1/4000/1/0", mem_read, mem_address, indirect_op, mem_resp_fwd); end
        step();
        mem_rdata = 16'h0042; #1;
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h5000 || indirect_op !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL ldi_acc2 got rd=%b a=%h ind=%b st=%b exp 1/5000/0/1", mem_read, mem_address, indirect_op, stall); end
        total++; if (mem_resp_fwd !== 1'b1 || r_mem !== 1'b1) begin bad++; $display("FAIL ldi_fwd got fwd=%b rm=%b exp 1/1", mem_resp_fwd, r_mem); end
        step();
        mem_resp = 1'b0; op_valid = 1'b0; #1;
        total++; if (ld_data !== 16'h0042 || ld_valid !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL ldi_done got d=%h v=%b st=%b exp 0042/1/0", ld_data, ld_valid, stall); end
        step();
    endtask

    task automatic test_sti();
        op_valid = 1'b1; op = MOP_STI; addr = 16'h4010; st_data = 16'hCAFE;
        step();
        mem_resp = 1'b1; mem_rdata = 16'h6002; #1;
        total++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 16'h4010 || indirect_op !== 1'b1) begin bad++; $display("FAIL sti_acc1 got rd=%b wr=%b a=%h ind=%b exp 1/0/4010/1", mem_read, mem_write, mem_address, indirect_op); end
        step(); #1;
        total++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 16'h6002 || mem_wdata !== 16'hCAFE || mem_byte_enable !== 2'b11) begin bad++; $display("FAIL sti_acc2 got wr=%b rd=%b a=%h wd=%h be=%b exp 1/0/6002/cafe/11", mem_write, mem_read, mem_address, mem_wdata, mem_byte_enable); end
        total++; if (mem_resp_fwd !== 1'b0) begin bad++; $display("FAIL sti_fwd got=%b exp=0", mem_resp_fwd); end
        step();
        mem_resp = 1'b0; op_valid = 1'b0; #1;
        total++; if (ld_valid !== 1'b0 || ld_data !== 16'h0042 || stall !== 1'b0) begin bad++; $display("FAIL sti_done got v=%b d=%h st=%b exp 0/0042/0", ld_valid, ld_data, stall); end
        step();
    endtask

    task automatic test_flush();
        op_valid = 1'b1; op = MOP_LDW; addr = 16'h1000;
        step();
        flush = 1'b1; #1;
        total++; if (mem_read !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL flush_acc1 got rd=%b st=%b exp 1/1", mem_read, stall); end
        step();
        flush = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h1111; #1;
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h1000) begin bad++; $display("FAIL flush_continue got rd=%b a=%h exp 1/1000", mem_read, mem_address); end
        step();
        mem_resp = 1'b0; op_valid = 1'b0; #1;
        total++; if (ld_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL flush_squash got v=%b st=%b exp 0/0", ld_valid, stall); end
        step();
        // flush while LDW waits in IDLE: nothing starts
        op_valid = 1'b1; op = MOP_LDW; addr = 16'h1002; flush = 1'b1; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b exp=0", stall); end
        step(); #1;
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL flush_idle_strobe got rd=%b wr=%b st=%b exp 0/0/0", mem_read, mem_write, stall); end
        // stray response in IDLE is ignored
        flush = 1'b0; op_valid = 1'b0; mem_resp = 1'b1;
        step();
        mem_resp = 1'b0; #1;
        total++; if (mem_read !== 1'b0 || stall !== 1'b0 || ld_valid !== 1'b0) begin bad++; $display("FAIL idle_resp got rd=%b st=%b v=%b exp 0/0/0", mem_read, stall, ld_valid); end
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; op = MOP_LDI; addr = 16'h4000;
        step();
        mem_resp = 1'b1; mem_rdata = 16'h5000;
        step();
        mem_resp = 1'b0; reset = 1'b1; op_valid = 1'b0; #1;
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h5000) begin bad++; $display("FAIL rst_mid_acc2 got rd=%b a=%h exp 1/5000", mem_read, mem_address); end
        step();
        reset = 1'b0; #1;
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || stall !== 1'b0 || ld_data !== 16'h0000) begin bad++; $display("FAIL rst_mid_idle got rd=%b wr=%b st=%b d=%h exp 0/0/0/0000", mem_read, mem_write, stall, ld_data); end
`ifdef MEM_PERF_EN
        total++; if (perf_acc_cnt !== 16'd0 || perf_stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_perf got=%0d/%0d exp=0/0", perf_acc_cnt, perf_stall_cnt); end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_ldw();
        test_byte();
        test_ldi();
        test_sti();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
